// File: rtl/data_main_memory_if.sv
// Cache-to-main-memory block port: 128-bit block transfers addressed by
// block number, with busywait holding the cache while the access runs.
interface data_main_memory_if;
    logic         read;
    logic         write;
    logic [27:0]  address;
    logic [127:0] writedata;
    logic [127:0] readdata;
    logic         busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/data_main_memory.sv
// Block-granular data main memory with fixed access latency, sitting behind
// the data cache; requests are latched on acceptance and complete LATENCY edges later.
module data_main_memory #(
    parameter int INDEX_BITS = 8,
    parameter int LATENCY    = 5
) (
    input logic                  clock,
    input logic                  reset,
    data_main_memory_if.slave    bus
);

    localparam int DEPTH = 2 ** INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state;
    logic [7:0]              count;
    logic [INDEX_BITS-1:0]   lat_index;
    logic                    lat_write;
    logic [127:0]            lat_data;
    logic [127:0]            readdata_q;
    logic [127:0]            mem [DEPTH];
    logic                    complete;
    logic                    unused_addr_bits;

    // Upper block-address bits alias onto the decoded range.
    assign unused_addr_bits = ^bus.address[27:INDEX_BITS];

    assign complete     = (state == BUSY) && (count == 8'd0);
    assign bus.readdata = readdata_q;
    assign bus.busywait = reset &&
                          (((state == IDLE) && (bus.read || bus.write)) || (state == BUSY));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= 8'd0;
            lat_index  <= '0;
            lat_write  <= 1'b0;
            lat_data   <= '0;
            readdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.read || bus.write) begin
                        lat_index <= bus.address[INDEX_BITS-1:0];
                        lat_write <= bus.write;
                        lat_data  <= bus.writedata;
                        count     <= 8'(LATENCY - 1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == 8'd0) begin
                        if (!lat_write) begin
                            readdata_q <= mem[lat_index];
                        end
                        state <= DONE;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                // DONE ignores requests so a held request is not retriggered here.
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array is never reset; a reset drops the FSM to IDLE so an in-flight write never lands.
    always_ff @(posedge clock) begin
        if (reset && complete && lat_write) begin
            mem[lat_index] <= lat_data;
        end
    end

endmodule

// File: tb/tb_data_main_memory.sv
// Directed scoreboard bench for data_main_memory: latency, back-to-back
// transfers, input stability, write priority, mid-access reset and aliasing.
module tb_data_main_memory;

    localparam int INDEX_BITS = 8;
    localparam int LATENCY    = 5;

    logic clock;
    logic reset;

    data_main_memory_if bus ();

    data_main_memory #(
        .INDEX_BITS (INDEX_BITS),
        .LATENCY    (LATENCY)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q [$];
    logic [127:0] model_mem [256];
    logic [127:0] model_rdata;

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One transaction: optional idle cycle, drive, count busy cycles, check data in DONE.
    task automatic apply_stimulus(input string tag, input logic rd, input logic wr,
                                  input logic [27:0] addr, input logic [127:0] data,
                                  input bit from_done, input bit keep_req,
                                  input bit junk, input logic [27:0] junk_addr);
        int cycles;
        if (!from_done) begin
            @(negedge clock);
            check_output({tag, "_idle"}, {127'd0, bus.busywait}, 128'd0);
        end
        bus.read      = rd;
        bus.write     = wr;
        bus.address   = addr;
        bus.writedata = data;
        if (wr) model_mem[addr[7:0]] = data;
        if (rd && !wr) exp_q.push_back(model_mem[addr[7:0]]);
        else           exp_q.push_back(model_rdata);
        if (from_done) begin
            #1;
            check_output({tag, "_gap"}, {127'd0, bus.busywait}, 128'd0);
            @(negedge clock);
        end
        #1;
        check_output({tag, "_c0"}, {127'd0, bus.busywait}, 128'd1);
        cycles = 1;
        forever begin
            @(negedge clock);
            if (!bus.busywait || cycles > 300) break;
            cycles++;
            if (junk && cycles == 3) begin
                bus.address   = junk_addr;
                bus.writedata = ~data;
            end
        end
        check_output({tag, "_len"}, 128'(cycles), 128'(LATENCY + 1));
        model_rdata = exp_q.pop_front();
        check_output({tag, "_data"}, bus.readdata, model_rdata);
        if (!keep_req) begin
            bus.read  = 1'b0;
            bus.write = 1'b0;
        end
    endtask

    localparam logic [127:0] D1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] DA5  = {16{8'hA5}};
    localparam logic [127:0] DNEW = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    localparam logic [127:0] D2   = 128'h0BADCAFE_13579BDF_2468ACE0_55AA55AA;
    localparam logic [127:0] D44  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] DBTH = 128'hC0FFEE00_C0FFEE11_C0FFEE22_C0FFEE33;
    localparam logic [127:0] D11  = {32{4'h1}};
    localparam logic [127:0] D7N  = 128'h77777777_66666666_55555555_99999999;
    localparam logic [127:0] DALI = 128'hABCDEF01_23456789_FEDCBA98_76543210;

    initial begin
        model_rdata   = '0;
        reset         = 1'b0;
        bus.read      = 1'b1;
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;

        // Reset with a request present: busywait must stay low.
        repeat (2) @(negedge clock);
        #1;
        check_output("rst_busy", {127'd0, bus.busywait}, 128'd0);
        check_output("rst_rdata", bus.readdata, 128'd0);
        bus.read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_output("post_rst_busy", {127'd0, bus.busywait}, 128'd0);
        check_output("post_rst_rdata", bus.readdata, 128'd0);

        $display("[TB] write then read");
        apply_stimulus("wr3", 1'b0, 1'b1, 28'h0000003, D1, 1'b0, 1'b0, 1'b0, 28'h0);
        apply_stimulus("rd3", 1'b1, 1'b0, 28'h0000003, '0, 1'b0, 1'b0, 1'b0, 28'h0);

        $display("[TB] writeback then refill");
        apply_stimulus("init20", 1'b0, 1'b1, 28'h0000020, DA5, 1'b0, 1'b0, 1'b0, 28'h0);
        apply_stimulus("wb10", 1'b0, 1'b1, 28'h0000010, DNEW, 1'b0, 1'b1, 1'b0, 28'h0);
        apply_stimulus("refill20", 1'b1, 1'b0, 28'h0000020, '0, 1'b1, 1'b0, 1'b0, 28'h0);
        apply_stimulus("rd10", 1'b1, 1'b0, 28'h0000010, '0, 1'b0, 1'b0, 1'b0, 28'h0);

        $display("[TB] input stability");
        apply_stimulus("init44", 1'b0, 1'b1, 28'h0000044, D44, 1'b0, 1'b0, 1'b0, 28'h0);
        apply_stimulus("wr9junk", 1'b0, 1'b1, 28'h0000009, D2, 1'b0, 1'b0, 1'b1, 28'h0000044);
        apply_stimulus("rd9", 1'b1, 1'b0, 28'h0000009, '0, 1'b0, 1'b0, 1'b0, 28'h0);
        apply_stimulus("rd44", 1'b1, 1'b0, 28'h0000044, '0, 1'b0, 1'b0, 1'b0, 28'h0);
        apply_stimulus("rd3junk", 1'b1, 1'b0, 28'h0000003, '0, 1'b0, 1'b0, 1'b1, 28'h0000009);

        $display("[TB] read and write together");
        apply_stimulus("both5", 1'b1, 1'b1, 28'h0000005, DBTH, 1'b0, 1'b0, 1'b0, 28'h0);
        apply_stimulus("rd5", 1'b1, 1'b0, 28'h0000005, '0, 1'b0, 1'b0, 1'b0, 28'h0);

        $display("[TB] mid-operation reset");
        apply_stimulus("init7", 1'b0, 1'b1, 28'h0000007, D11, 1'b0, 1'b0, 1'b0, 28'h0);
        @(negedge clock);
        bus.write     = 1'b1;
        bus.address   = 28'h0000007;
        bus.writedata = D7N;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_output("midrst_busy", {127'd0, bus.busywait}, 128'd0);
        check_output("midrst_rdata", bus.readdata, 128'd0);
        bus.write   = 1'b0;
        model_rdata = '0;
        @(negedge clock);
        reset = 1'b1;
        apply_stimulus("rd7", 1'b1, 1'b0, 28'h0000007, '0, 1'b0, 1'b0, 1'b0, 28'h0);

        $display("[TB] aliasing");
        apply_stimulus("wr105", 1'b0, 1'b1, 28'h0000105, DALI, 1'b0, 1'b0, 1'b0, 28'h0);
        apply_stimulus("rd005", 1'b1, 1'b0, 28'h0000005, '0, 1'b0, 1'b0, 1'b0, 28'h0);

        @(negedge clock);
        check_output("final_idle", {127'd0, bus.busywait}, 128'd0);
        check_output("final_rdata", bus.readdata, DALI);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
